// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer read arbiter.
//   owner_e : who issued a read (routes returning data)
//   state_e : arbiter FSM states
//   tag_t   : one in-flight read slot {valid, owner}
package fb_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_AUX} owner_e;
  typedef enum logic [1:0] {IDLE, SCAN, COOLDOWN, AUX} state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_NONE};

  // Bits needed to hold 0..n (at least 1).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fb_arb_tag_pipe.sv
// Latency-matched owner-tag shift register. A tag entered with a read issue
// appears at tag_out exactly DEPTH cycles later, aligned with BRAM data.
// Async clear drops every in-flight tag so no data valid follows a reset.
//   clk, rst_n : clock, async active-low clear
//   tag_in     : tag of the read issued this cycle (valid=0 when none)
//   tag_out    : tag whose data is on the BRAM output this cycle
module fb_arb_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: VGA scanout always wins; an auxiliary
// reader gets the port only after HOLDOFF scanout-free cycles, in bursts of
// at most AUX_MAX_BURST grants separated by one forced idle cycle.
// Returning data is steered by an owner-tag pipe matched to RD_LATENCY.
// Optional build macro FB_ARB_STATS_EN adds aux_grant_cnt / aux_stall_cnt.
//   pclk, rst_n              : clock, async active-low reset
//   vga_req/vga_addr         : scanout request (never stalled)
//   vga_data/vga_dv          : scanout read data
//   aux_req/aux_addr/aux_gnt : aux request, held until the 1-cycle grant
//   aux_data/aux_dv          : aux read data
//   mem_en/mem_addr/mem_data : BRAM read port
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter  int RESOLUTION_WIDTH  = 640,
  parameter  int RESOLUTION_HEIGHT = 480,
  parameter  int DATA_W            = 4,
  parameter  int RD_LATENCY        = 1,
  parameter  int HOLDOFF           = 2,
  parameter  int AUX_MAX_BURST     = 16,
  localparam int ADDR_W = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT) + 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_dv,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_dv,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]       aux_grant_cnt,
  output logic [31:0]       aux_stall_cnt
`endif
);
  localparam int HW = cnt_w(HOLDOFF);
  localparam int BW = cnt_w(AUX_MAX_BURST);

  state_e          state;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   burst;
  logic            elig;
  tag_t            tag_in, tag_tail;
  logic [DATA_W-1:0] vga_hold, aux_hold;

  // With HOLDOFF=0 the first scanout-free cycle already follows IDLE rules.
  assign elig = (burst < BW'(AUX_MAX_BURST)) &&
                (state == IDLE || state == AUX || (state == SCAN && HOLDOFF == 0));

  assign aux_gnt  = !vga_req && aux_req && elig;
  assign mem_en   = vga_req || aux_gnt;
  assign mem_addr = vga_req ? vga_addr : (aux_gnt ? aux_addr : '0);

  always_comb begin
    tag_in = TAG_NONE;
    if (vga_req)      tag_in = '{valid: 1'b1, owner: OWN_VGA};
    else if (aux_gnt) tag_in = '{valid: 1'b1, owner: OWN_AUX};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      burst    <= '0;
    end else if (vga_req) begin
      state    <= SCAN;
      hold_cnt <= '0;
      burst    <= '0;
    end else begin
      case (state)
        // First scanout-free cycle counts as holdoff cycle #1.
        SCAN, IDLE: begin
          if (state == SCAN && HOLDOFF == 1) begin
            state <= IDLE;
          end else if (state == SCAN && HOLDOFF > 1) begin
            state    <= COOLDOWN;
            hold_cnt <= HW'(1);
          end else if (aux_gnt) begin
            state <= AUX;
            burst <= BW'(1);
          end else begin
            state <= IDLE;
          end
        end
        COOLDOWN: begin
          if (hold_cnt == HW'(HOLDOFF - 1)) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        // A missing grant (request dropped or burst cap reached) is the
        // forced idle cycle; the burst count restarts after it.
        AUX: begin
          if (aux_gnt) begin
            burst <= burst + 1'b1;
          end else begin
            state <= IDLE;
            burst <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fb_arb_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk    (pclk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_tail)
  );

  assign vga_dv = tag_tail.valid && tag_tail.owner == OWN_VGA;
  assign aux_dv = tag_tail.valid && tag_tail.owner == OWN_AUX;

  // Non-owning data output keeps its last delivered value.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hold <= '0;
      aux_hold <= '0;
    end else begin
      if (vga_dv) vga_hold <= mem_data;
      if (aux_dv) aux_hold <= mem_data;
    end
  end

  assign vga_data = vga_dv ? mem_data : vga_hold;
  assign aux_data = aux_dv ? mem_data : aux_hold;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      aux_grant_cnt <= '0;
      aux_stall_cnt <= '0;
    end else begin
      if (aux_gnt && aux_grant_cnt != '1)                aux_grant_cnt <= aux_grant_cnt + 1'b1;
      if (aux_req && !aux_gnt && aux_stall_cnt != '1)    aux_stall_cnt <= aux_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Bench for fb_read_arbiter: two instances (RD_LATENCY 1 and 3) share one
// stimulus stream. A reference model decides each cycle's grant from plain
// counters (cycles since scanout, consecutive grants); issued reads are
// queued and a monitor matches every returned dv against the queue.
module tb_fb_read_arbiter;
  localparam int ADDR_W  = $clog2(640 * 480) + 1;
  localparam int HOLDOFF = 2;
  localparam int MAXB    = 16;

  typedef struct {
    int         cyc;
    logic       own_vga;
    logic [3:0] data;
  } exp_t;

  logic pclk, rst_n;
  logic vga_req, aux_req;
  logic [ADDR_W-1:0] vga_addr, aux_addr;
  logic [1:0] vga_dv_w, aux_dv_w, aux_gnt_w, mem_en_w;
  logic [1:0][ADDR_W-1:0] mem_addr_w;
  logic [1:0][3:0] vga_data_w, aux_data_w, mem_data_w;
`ifdef FB_ARB_STATS_EN
  logic [1:0][31:0] gcnt_w, scnt_w;
`endif

  int vectors = 0, errors = 0, cyc = 0;
  exp_t q[$];
  int rd[2];

  // reference model state
  int since_vga, run, ngrant;
  logic aux_pend, last_gnt;
  logic [ADDR_W-1:0] aux_pend_addr;

  function automatic logic [3:0] memf(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[19:16] ^ 4'h5;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  fb_read_arbiter #(.RD_LATENCY(1)) u_l1 (
    .pclk(pclk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data_w[0]), .vga_dv(vga_dv_w[0]),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt_w[0]),
    .aux_data(aux_data_w[0]), .aux_dv(aux_dv_w[0]),
    .mem_en(mem_en_w[0]), .mem_addr(mem_addr_w[0]), .mem_data(mem_data_w[0])
`ifdef FB_ARB_STATS_EN
    , .aux_grant_cnt(gcnt_w[0]), .aux_stall_cnt(scnt_w[0])
`endif
  );

  fb_read_arbiter #(.RD_LATENCY(3)) u_l3 (
    .pclk(pclk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data_w[1]), .vga_dv(vga_dv_w[1]),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt_w[1]),
    .aux_data(aux_data_w[1]), .aux_dv(aux_dv_w[1]),
    .mem_en(mem_en_w[1]), .mem_addr(mem_addr_w[1]), .mem_data(mem_data_w[1])
`ifdef FB_ARB_STATS_EN
    , .aux_grant_cnt(gcnt_w[1]), .aux_stall_cnt(scnt_w[1])
`endif
  );

  // BRAM models: address delay lines of depth 1 and 3
  logic [ADDR_W-1:0] a1, a3_0, a3_1, a3_2;
  always_ff @(posedge pclk) begin
    a1   <= mem_addr_w[0];
    a3_0 <= mem_addr_w[1];
    a3_1 <= a3_0;
    a3_2 <= a3_1;
  end
  assign mem_data_w[0] = memf(a1);
  assign mem_data_w[1] = memf(a3_2);

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic model_reset();
    since_vga = HOLDOFF;
    run       = 0;
    aux_pend  = 1'b0;
  endtask

  // One cycle: drive inputs at negedge, check issue-side outputs, update model.
  task automatic drive_cycle(input logic vr, input logic [ADDR_W-1:0] va);
    logic eg;
    logic [ADDR_W-1:0] ea;
    exp_t e;
    @(negedge pclk);
    vga_req  = vr;
    vga_addr = va;
    aux_req  = aux_pend;
    aux_addr = aux_pend_addr;
    #1;
    eg = !vr && aux_pend && since_vga >= HOLDOFF && run < MAXB;
    ea = vr ? va : (eg ? aux_pend_addr : '0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("aux_gnt[%0d]", i), 32'(aux_gnt_w[i]), 32'(eg));
      chk($sformatf("mem_en[%0d]", i), 32'(mem_en_w[i]), 32'(vr || eg));
      chk($sformatf("mem_addr[%0d]", i), 32'(mem_addr_w[i]), 32'(ea));
    end
    if (vr || eg) begin
      e.cyc = cyc; e.own_vga = vr; e.data = memf(ea);
      q.push_back(e);
    end
    since_vga = vr ? 0 : (since_vga < 1000 ? since_vga + 1 : since_vga);
    run       = eg ? run + 1 : 0;
    last_gnt  = eg;
    if (eg) begin
      aux_pend = 1'b0;
      ngrant++;
    end
  endtask

  // Return-path monitor
  initial begin : monitor
    logic [3:0] lastv[2], lasta[2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin lastv[i] = '0; lasta[i] = '0; end
    forever begin
      @(negedge pclk);
      #3;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          lastv[i] = '0;
          lasta[i] = '0;
        end
        if (vga_dv_w[i] && aux_dv_w[i])
          chk($sformatf("both_dv[%0d]", i), 32'(1), 32'(0));
        if (vga_dv_w[i] || aux_dv_w[i]) begin
          if (rd[i] >= q.size()) begin
            chk($sformatf("spurious_dv[%0d]", i), 32'(1), 32'(0));
          end else begin
            e = q[rd[i]];
            rd[i]++;
            chk($sformatf("dv_time[%0d]", i), 32'(cyc), 32'(e.cyc + lat(i)));
            chk($sformatf("dv_owner[%0d]", i), 32'(vga_dv_w[i]), 32'(e.own_vga));
            if (e.own_vga) lastv[i] = e.data;
            else           lasta[i] = e.data;
          end
        end else if (rd[i] < q.size() && q[rd[i]].cyc + lat(i) <= cyc) begin
          chk($sformatf("missing_dv[%0d]", i), 32'(0), 32'(1));
          rd[i]++;
        end
        chk($sformatf("vga_data[%0d]", i), 32'(vga_data_w[i]), 32'(lastv[i]));
        chk($sformatf("aux_data[%0d]", i), 32'(aux_data_w[i]), 32'(lasta[i]));
      end
    end
  end

  initial begin : stim
    int vga_left, k, n0;
    logic vr;
    logic [ADDR_W-1:0] next_addr;
    rst_n = 1'b1; vga_req = 1'b0; aux_req = 1'b0; vga_addr = '0; aux_addr = '0;
    rd[0] = 0; rd[1] = 0; ngrant = 0; last_gnt = 1'b0; aux_pend_addr = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
`ifdef FB_ARB_STATS_EN
    #1;
    chk("stats_grant_rst", gcnt_w[1], 32'd0);
    chk("stats_stall_rst", scnt_w[0], 32'd0);
`endif

    // idle after reset
    repeat (10) drive_cycle(1'b0, '0);

    // single aux read at 0x10
    aux_pend = 1'b1; aux_pend_addr = 20'h10;
    drive_cycle(1'b0, '0);
    chk("aux_single_gnt", 32'(last_gnt), 32'd1);
    repeat (4) drive_cycle(1'b0, '0);

    // vga and aux contend for 5 cycles; aux waits out the holdoff
    aux_pend = 1'b1; aux_pend_addr = 20'h20;
    for (int j = 0; j < 5; j++) drive_cycle(1'b1, ADDR_W'(100 + j));
    k = -1;
    for (int j = 0; j < 10 && k < 0; j++) begin
      drive_cycle(1'b0, '0);
      if (last_gnt) k = j;
    end
    chk("holdoff_gap", 32'(k), 32'(HOLDOFF));
    repeat (4) drive_cycle(1'b0, '0);

    // aux held 40 cycles: 16 + gap + 16 + gap + 6
    n0 = ngrant;
    next_addr = 20'h400;
    for (int j = 0; j < 40; j++) begin
      if (!aux_pend) begin aux_pend = 1'b1; aux_pend_addr = next_addr; next_addr++; end
      drive_cycle(1'b0, '0);
    end
    chk("burst_grants", 32'(ngrant - n0), 32'd38);
    aux_pend = 1'b0;
    repeat (5) drive_cycle(1'b0, '0);

    // randomized traffic
    vga_left = 0;
    for (int j = 0; j < 3000; j++) begin
      if (aux_pend && $urandom_range(19) == 0) aux_pend = 1'b0;
      else if (!aux_pend && $urandom_range(2) == 0) begin
        aux_pend = 1'b1;
        aux_pend_addr = ADDR_W'($urandom_range(307199));
      end
      if (vga_left == 0 && $urandom_range(7) == 0) vga_left = $urandom_range(20, 1);
      vr = (vga_left > 0) || ($urandom_range(15) == 0);
      if (vga_left > 0) vga_left--;
      drive_cycle(vr, ADDR_W'($urandom_range(307199)));
    end
    aux_pend = 1'b0;
    repeat (6) drive_cycle(1'b0, '0);
    chk("drained_l1", 32'(rd[0]), 32'(q.size()));
    chk("drained_l3", 32'(rd[1]), 32'(q.size()));

    // reset with reads in flight: nothing may come back
    aux_pend = 1'b1; aux_pend_addr = 20'h33;
    drive_cycle(1'b1, 20'h1234);
    drive_cycle(1'b0, '0);
    @(negedge pclk);
    vga_req = 1'b0; aux_req = 1'b0;
    rst_n = 1'b0;
    rd[0] = q.size(); rd[1] = q.size();
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
`ifdef FB_ARB_STATS_EN
    #1;
    chk("stats_grant_midrst", gcnt_w[0], 32'd0);
    chk("stats_stall_midrst", scnt_w[1], 32'd0);
`endif
    repeat (8) drive_cycle(1'b0, '0);
    chk("post_rst_l1", 32'(rd[0]), 32'(q.size()));
    chk("post_rst_l3", 32'(rd[1]), 32'(q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
